// File: rtl/scan_pkg.sv
// Shared constants and state encoding for the channel scanner.
package scan_pkg;
  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  typedef enum logic {IDLE, ACTIVE} scan_state_t;
endpackage

// File: rtl/scan_sequencer_next_ch_finder.sv
// Combinational search of the enable mask: lowest enabled channel, and the
// lowest enabled channel strictly above the current index.
module next_ch_finder
  import scan_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W-1:0]  cur,
  output logic [SEL_W-1:0]  next_idx,
  output logic              next_found,
  output logic [SEL_W-1:0]  first_idx
);

  // Scanning downward lets the last hit be the lowest qualifying index.
  always_comb begin
    next_idx   = '0;
    next_found = 1'b0;
    first_idx  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) first_idx = SEL_W'(i);
      if (mask[i] && (SEL_W'(i) > cur)) begin
        next_idx   = SEL_W'(i);
        next_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/scan_sequencer.sv
// Channel scanner driving a 3-to-8 decoder: steps through enabled channels,
// holding each for dwell+1 cycles, single pass or continuous.
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               continuous,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [NUM_CH-1:0]  ch_mask,
  output logic [SEL_W-1:0]   sel,
  output logic               sel_en,
  output logic               busy,
  output logic               done,
  output logic               wrap
);

  scan_state_t         state;
  logic [DWELL_W-1:0]  cnt;
  logic [DWELL_W-1:0]  dwell_q;
  logic [NUM_CH-1:0]   mask_q;
  logic                cont_q;

  logic [NUM_CH-1:0]   find_mask;
  logic [SEL_W-1:0]    next_idx;
  logic                next_found;
  logic [SEL_W-1:0]    first_idx;

  // In IDLE the finder looks at the live mask so the first channel is ready
  // on the start edge; once scanning it only sees the latched copy.
  assign find_mask = (state == IDLE) ? ch_mask : mask_q;

  next_ch_finder u_finder (
    .mask       (find_mask),
    .cur        (sel),
    .next_idx   (next_idx),
    .next_found (next_found),
    .first_idx  (first_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      dwell_q <= '0;
      mask_q  <= '0;
      cont_q  <= 1'b0;
      sel     <= '0;
      sel_en  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      done <= 1'b0;
      wrap <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop && (ch_mask != '0)) begin
            state   <= ACTIVE;
            mask_q  <= ch_mask;
            dwell_q <= dwell;
            cont_q  <= continuous;
            sel     <= first_idx;
            cnt     <= dwell;
            sel_en  <= 1'b1;
            busy    <= 1'b1;
          end
        end
        ACTIVE: begin
          // Stop outranks both advance and wrap.
          if (stop) begin
            state  <= IDLE;
            sel_en <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b1;
          end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (next_found) begin
            sel <= next_idx;
            cnt <= dwell_q;
          end else if (cont_q) begin
            sel  <= first_idx;
            cnt  <= dwell_q;
            wrap <= 1'b1;
          end else begin
            state  <= IDLE;
            sel_en <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench: per-cycle expected outputs are queued from a channel-list
// model and popped against the DUT one cycle at a time.
module tb_scan_sequencer;

  typedef struct packed {
    logic [2:0] sel;
    logic       sel_en;
    logic       busy;
    logic       done;
    logic       wrap;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       continuous;
  logic [7:0] dwell;
  logic [7:0] ch_mask;
  logic [2:0] sel;
  logic       sel_en;
  logic       busy;
  logic       done;
  logic       wrap;

  exp_t q[$];
  int   npass;
  int   ntot;
  int   cyc;

  scan_sequencer #(.DWELL_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .continuous (continuous),
    .dwell      (dwell),
    .ch_mask    (ch_mask),
    .sel        (sel),
    .sel_en     (sel_en),
    .busy       (busy),
    .done       (done),
    .wrap       (wrap)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t mk(input logic [2:0] s, input logic en, input logic b,
                              input logic d, input logic w);
    exp_t e;
    e.sel = s; e.sel_en = en; e.busy = b; e.done = d; e.wrap = w;
    return e;
  endfunction

  // Queue one pass over the enabled channels; wrap_first marks the first
  // cycle of the lowest channel as a wrap.
  task automatic push_pass(input logic [7:0] m, input int dw, input logic wrap_first);
    bit first = 1'b1;
    for (int ch = 0; ch < 8; ch++) begin
      if (m[ch]) begin
        for (int k = 0; k <= dw; k++)
          q.push_back(mk(3'(ch), 1'b1, 1'b1, 1'b0, (first && wrap_first && k == 0)));
        first = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic cmp(input string tag, input exp_t e);
    exp_t got;
    got = '{sel: sel, sel_en: sel_en, busy: busy, done: done, wrap: wrap};
    ntot++;
    assert (got === e) npass++;
    else $error("FAIL %s cyc=%0d: got sel=%0d en=%b busy=%b done=%b wrap=%b, expected sel=%0d en=%b busy=%b done=%b wrap=%b",
                tag, cyc, got.sel, got.sel_en, got.busy, got.done, got.wrap,
                e.sel, e.sel_en, e.busy, e.done, e.wrap);
  endtask

  // Pop and compare one expectation per cycle, advancing the clock after each.
  task automatic check(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      if (q.size() == 0) begin
        ntot++;
        $error("FAIL %s: scoreboard empty, got sel=%0d en=%b, expected queued entry", tag, sel, sel_en);
      end else begin
        cmp(tag, q.pop_front());
      end
      tick();
    end
  endtask

  initial begin
    npass = 0; ntot = 0; cyc = 0;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; continuous = 1'b0;
    dwell = 8'd0; ch_mask = 8'h00;
    #1;
    cmp("reset", mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    #11 rst_n = 1'b1;

    // Single pass 0,2,5,7 with dwell 2.
    ch_mask = 8'hA5; dwell = 8'd2; continuous = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    push_pass(8'hA5, 2, 1'b0);
    q.push_back(mk(3'd7, 1'b0, 1'b0, 1'b1, 1'b0));
    q.push_back(mk(3'd7, 1'b0, 1'b0, 1'b0, 1'b0));
    check("single", 14);

    // Continuous 0/7 dwell 0, stop on the cycle that would otherwise wrap.
    ch_mask = 8'h81; dwell = 8'd0; continuous = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    push_pass(8'h81, 0, 1'b0);
    push_pass(8'h81, 0, 1'b1);
    push_pass(8'h81, 0, 1'b1);
    check("cont", 5);
    stop = 1'b1;
    check("cont", 1);
    stop = 1'b0;
    q.push_back(mk(3'd7, 1'b0, 1'b0, 1'b1, 1'b0));
    q.push_back(mk(3'd7, 1'b0, 1'b0, 1'b0, 1'b0));
    check("stop", 2);

    // Empty mask start, then start+stop together: both ignored.
    ch_mask = 8'h00; continuous = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    q.push_back(mk(3'd7, 1'b0, 1'b0, 1'b0, 1'b0));
    q.push_back(mk(3'd7, 1'b0, 1'b0, 1'b0, 1'b0));
    check("zero_mask", 2);
    ch_mask = 8'h01; start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    q.push_back(mk(3'd7, 1'b0, 1'b0, 1'b0, 1'b0));
    q.push_back(mk(3'd7, 1'b0, 1'b0, 1'b0, 1'b0));
    check("start_stop", 2);

    // Latched config ignores mid-scan changes and extra starts.
    ch_mask = 8'h12; dwell = 8'd1; continuous = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    push_pass(8'h12, 1, 1'b0);
    q.push_back(mk(3'd4, 1'b0, 1'b0, 1'b1, 1'b0));
    q.push_back(mk(3'd4, 1'b0, 1'b0, 1'b0, 1'b0));
    check("latch", 1);
    ch_mask = 8'hFF; dwell = 8'd0; continuous = 1'b1; start = 1'b1;
    check("latch", 1);
    start = 1'b0;
    check("latch", 1);
    start = 1'b1;
    check("latch", 1);
    start = 1'b0;
    check("latch", 2);

    // Reset during dwell of channel 3: immediate clear, no done.
    ch_mask = 8'h0C; dwell = 8'd3; continuous = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    push_pass(8'h0C, 3, 1'b0);
    check("pre_rst", 6);
    q.delete();
    #2 rst_n = 1'b0;
    #1 cmp("async_rst", mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    tick();
    cmp("rst_hold", mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    rst_n = 1'b1;

    ch_mask = 8'h10; dwell = 8'd0; continuous = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    q.push_back(mk(3'd4, 1'b1, 1'b1, 1'b0, 1'b0));
    q.push_back(mk(3'd4, 1'b0, 1'b0, 1'b1, 1'b0));
    check("post_rst", 1);

    // Back-to-back start on the done cycle, full-range dwell.
    ch_mask = 8'h80; dwell = 8'd255; start = 1'b1;
    check("post_rst", 1);
    start = 1'b0;
    push_pass(8'h80, 255, 1'b0);
    q.push_back(mk(3'd7, 1'b0, 1'b0, 1'b1, 1'b0));
    q.push_back(mk(3'd7, 1'b0, 1'b0, 1'b0, 1'b0));
    check("b2b", 258);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
